// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the RV32I instruction encoder:
//   - enc_op_e   : mnemonic request codes (ENC_*) accepted on in_op
//   - ENC_LAST   : highest legal mnemonic code
//   - OPC_*      : RV32I major opcodes (instr[6:0])
//   - enc_fmt_e  : instruction formats used to assemble the 32-bit word
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  typedef enum logic [5:0] {
    ENC_ADD   = 6'd0,  ENC_SUB   = 6'd1,  ENC_XOR   = 6'd2,  ENC_OR    = 6'd3,
    ENC_AND   = 6'd4,  ENC_SLL   = 6'd5,  ENC_SRL   = 6'd6,  ENC_SRA   = 6'd7,
    ENC_SLT   = 6'd8,  ENC_SLTU  = 6'd9,
    ENC_ADDI  = 6'd10, ENC_XORI  = 6'd11, ENC_ORI   = 6'd12, ENC_ANDI  = 6'd13,
    ENC_SLLI  = 6'd14, ENC_SRLI  = 6'd15, ENC_SRAI  = 6'd16, ENC_SLTI  = 6'd17,
    ENC_SLTIU = 6'd18,
    ENC_LB    = 6'd19, ENC_LH    = 6'd20, ENC_LW    = 6'd21, ENC_LBU   = 6'd22,
    ENC_LHU   = 6'd23,
    ENC_SB    = 6'd24, ENC_SH    = 6'd25, ENC_SW    = 6'd26,
    ENC_BEQ   = 6'd27, ENC_BNE   = 6'd28, ENC_BLT   = 6'd29, ENC_BGE   = 6'd30,
    ENC_BLTU  = 6'd31, ENC_BGEU  = 6'd32,
    ENC_JAL   = 6'd33, ENC_JALR  = 6'd34, ENC_LUI   = 6'd35, ENC_AUIPC = 6'd36
  } enc_op_e;

  localparam logic [5:0] ENC_LAST = 6'd36;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // FMT_SH is the I-type shift-immediate layout (funct7 + 5-bit shamt).
  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U
  } enc_fmt_e;

endpackage

// File: rtl/instr_encoder_fmt.sv
// -----------------------------------------------------------------------------
// instr_fmt
// Purely combinational mapping of a mnemonic request to an RV32I word.
// Ports:
//   op            : mnemonic code (enc_op_e values; anything above ENC_LAST is illegal)
//   rd, rs1, rs2  : register indices
//   imm           : signed byte offset / immediate (U-type: full 32-bit value)
//   legal         : request is encodable (op known, immediate in range/aligned)
//   word          : encoded instruction; unused fields are zero
// -----------------------------------------------------------------------------
module instr_fmt
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  function automatic logic fits_s12(logic signed [31:0] v);
    return (v >= -32'sd2048) && (v <= 32'sd2047);
  endfunction

  function automatic logic fits_s13(logic signed [31:0] v);
    return (v >= -32'sd4096) && (v <= 32'sd4095);
  endfunction

  function automatic logic fits_s21(logic signed [31:0] v);
    return (v >= -32'sd1048576) && (v <= 32'sd1048575);
  endfunction

  logic signed [31:0] simm;
  enc_fmt_e           fmt;
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;

  assign simm = signed'(imm);

  // Format and major opcode per mnemonic group.
  always_comb begin
    fmt = FMT_NONE;
    opc = '0;
    case (op)
      ENC_ADD, ENC_SUB, ENC_XOR, ENC_OR, ENC_AND,
      ENC_SLL, ENC_SRL, ENC_SRA, ENC_SLT, ENC_SLTU: begin fmt = FMT_R;  opc = OPC_OP;     end
      ENC_ADDI, ENC_XORI, ENC_ORI, ENC_ANDI,
      ENC_SLTI, ENC_SLTIU:                          begin fmt = FMT_I;  opc = OPC_OP_IMM; end
      ENC_SLLI, ENC_SRLI, ENC_SRAI:                 begin fmt = FMT_SH; opc = OPC_OP_IMM; end
      ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU:     begin fmt = FMT_I;  opc = OPC_LOAD;   end
      ENC_SB, ENC_SH, ENC_SW:                       begin fmt = FMT_S;  opc = OPC_STORE;  end
      ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE,
      ENC_BLTU, ENC_BGEU:                           begin fmt = FMT_B;  opc = OPC_BRANCH; end
      ENC_JAL:                                      begin fmt = FMT_J;  opc = OPC_JAL;    end
      ENC_JALR:                                     begin fmt = FMT_I;  opc = OPC_JALR;   end
      ENC_LUI:                                      begin fmt = FMT_U;  opc = OPC_LUI;    end
      ENC_AUIPC:                                    begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      default:                                      begin fmt = FMT_NONE; opc = '0;       end
    endcase
  end

  // funct3 / funct7 per mnemonic; anything not listed uses 0.
  always_comb begin
    f3 = 3'b000;
    f7 = 7'h00;
    case (op)
      ENC_SUB:                       f7 = 7'h20;
      ENC_XOR, ENC_XORI, ENC_LBU:    f3 = 3'b100;
      ENC_OR,  ENC_ORI,  ENC_BLTU:   f3 = 3'b110;
      ENC_AND, ENC_ANDI, ENC_BGEU:   f3 = 3'b111;
      ENC_SLL, ENC_SLLI, ENC_LH,
      ENC_SH,  ENC_BNE:              f3 = 3'b001;
      ENC_SRL, ENC_SRLI, ENC_LHU,
      ENC_BGE:                       f3 = 3'b101;
      ENC_SRA, ENC_SRAI:             begin f3 = 3'b101; f7 = 7'h20; end
      ENC_SLT, ENC_SLTI, ENC_LW,
      ENC_SW:                        f3 = 3'b010;
      ENC_SLTU, ENC_SLTIU:           f3 = 3'b011;
      ENC_BLT:                       f3 = 3'b100;
      default:                       begin f3 = 3'b000; f7 = 7'h00; end
    endcase
  end

  // Field assembly and immediate range/alignment checks.
  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (fmt)
      FMT_R:  word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        legal = fits_s12(simm);
        word  = {imm[11:0], rs1, f3, rd, opc};
      end
      FMT_SH: begin
        legal = (imm[31:5] == 27'd0);
        word  = {f7, imm[4:0], rs1, f3, rd, opc};
      end
      FMT_S: begin
        legal = fits_s12(simm);
        word  = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      end
      FMT_B: begin
        legal = fits_s13(simm) && !imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      end
      FMT_J: begin
        legal = fits_s21(simm) && !imm[0];
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      end
      FMT_U: begin
        legal = (imm[11:0] == 12'd0);
        word  = {imm[31:12], rd, opc};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I assembler: accepts mnemonic-level requests and emits encoded
// words with byte addresses for an instruction-memory write port.
// Parameters:
//   BASE_ADDR    : byte address of the first emitted word
//   DEPTH_WORDS  : memory depth in words, power of two >= 2 (address wraps)
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   flush                      : synchronous clear of output, address and status
//   in_valid/in_ready          : request handshake; in_op, in_rd, in_rs1, in_rs2, in_imm
//   out_valid/out_ready        : word handshake; out_addr, out_data
//   err, err_op, err_count     : sticky illegal flag, last illegal op, illegal count
//   instr_count                : words handed off (saturating)
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        err,
  output logic [5:0]  err_op,
  output logic [15:0] err_count,
  output logic [15:0] instr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic             fmt_legal_p0;
  logic [31:0]      fmt_word_p0;
  logic             accept_p0;
  logic             out_hs_p1;
  logic             vld_p1;
  logic [31:0]      data_p1;
  logic [IDX_W-1:0] widx_p1;

  instr_fmt u_fmt (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .legal (fmt_legal_p0),
    .word  (fmt_word_p0)
  );

  // Ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign out_hs_p1 = vld_p1 && out_ready;

  // ---- stage p0 -> p1: output register, address and status ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      widx_p1     <= '0;
      err         <= 1'b0;
      err_op      <= '0;
      err_count   <= '0;
      instr_count <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      widx_p1     <= '0;
      err         <= 1'b0;
      err_op      <= '0;
      err_count   <= '0;
      instr_count <= '0;
    end else begin
      // Power-of-two depth makes the natural index overflow the wrap.
      if (out_hs_p1) begin
        widx_p1     <= widx_p1 + 1'b1;
        instr_count <= sat_inc(instr_count);
      end
      if (accept_p0 && fmt_legal_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= fmt_word_p0;
      end else if (out_hs_p1) begin
        vld_p1 <= 1'b0;
      end
      // An illegal request leaves any pending word untouched.
      if (accept_p0 && !fmt_legal_p0) begin
        err       <= 1'b1;
        err_op    <= in_op;
        err_count <= sat_inc(err_count);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_addr  = BASE_ADDR + (32'(widx_p1) << 2);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        err;
  logic [5:0]  err_op;
  logic [15:0] err_count;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SRAI = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd26;
  localparam logic [5:0] OP_BEQ  = 6'd27;
  localparam logic [5:0] OP_JAL  = 6'd33;
  localparam logic [5:0] OP_LUI  = 6'd35;

  always #5 clk = ~clk;

  instr_encoder #(
    .BASE_ADDR   (32'h0000_0000),
    .DEPTH_WORDS (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .err         (err),
    .err_op      (err_op),
    .err_count   (err_count),
    .instr_count (instr_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
  endtask

  task automatic do_flush;
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_addr, out_data, err, err_op, err_count, instr_count, in_ready} !==
        {1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%0b a=%h d=%h e=%0b eo=%0d ec=%0d ic=%0d rdy=%0b want all zero, rdy=1",
               out_valid, out_addr, out_data, err, err_op, err_count, instr_count, in_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [3];
    logic [31:0] exp_a [3];
    exp_d = '{32'h002081B3, 32'hFFF00093, 32'h4030D093};
    exp_a = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        1:       req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        default: req(OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3);
      endcase
      tick();
      checks++;
      if ({out_valid, out_addr, out_data} !== {1'b1, exp_a[i], exp_d[i]}) begin
        errors++;
        $display("FAIL b2b_word%0d got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                 i, out_valid, out_addr, out_data, exp_a[i], exp_d[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, instr_count} !== {1'b0, 16'd3}) begin
      errors++;
      $display("FAIL b2b_count got v=%0b ic=%0d want v=0 ic=3", out_valid, instr_count);
    end
  endtask

  task automatic test_formats;
    logic [31:0] exp_d [4];
    exp_d = '{32'h0020A623, 32'h00208463, 32'h001000EF, 32'h123452B7};
    do_flush();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       req(OP_SW, 5'd0, 5'd1, 5'd2, 32'd12);
        1:       req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
        2:       req(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048);
        default: req(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      endcase
      tick();
      checks++;
      if ({out_valid, out_addr, out_data} !== {1'b1, 32'(i * 4), exp_d[i]}) begin
        errors++;
        $display("FAIL fmt_word%0d got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                 i, out_valid, out_addr, out_data, 32'(i * 4), exp_d[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal;
    do_flush();
    req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
        1:       req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd7);
        default: req(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
      endcase
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_no_output got v=%0b want 0", i, out_valid);
      end
    end
    checks++;
    if ({err, err_op, err_count, out_addr} !== {1'b1, 6'd40, 16'd3, 32'h4}) begin
      errors++;
      $display("FAIL illegal_status got e=%0b eo=%0d ec=%0d a=%h want e=1 eo=40 ec=3 a=00000004",
               err, err_op, err_count, out_addr);
    end
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    checks++;
    if ({out_valid, out_addr, out_data} !== {1'b1, 32'h4, 32'hFFF00093}) begin
      errors++;
      $display("FAIL illegal_next_legal got v=%0b a=%h d=%h want v=1 a=00000004 d=fff00093",
               out_valid, out_addr, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_boundaries;
    logic [5:0]  ops   [12];
    logic [31:0] imms  [12];
    logic        lg    [12];
    logic [31:0] words [12];
    ops   = '{6'd10, 6'd10, 6'd10, 6'd14, 6'd14, 6'd28, 6'd28, 6'd33, 6'd33, 6'd35, 6'd36, 6'd37};
    imms  = '{32'd2047, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31, 32'd32, 32'hFFFF_F000,
              32'd4096, 32'hFFFF_FFFE, 32'h0010_0000, 32'h0000_0001, 32'hFFFF_F000, 32'd0};
    lg    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    words = '{32'h7FF00013, 32'h80000013, 32'h0, 32'h01F01013, 32'h0, 32'h80001063,
              32'h0, 32'hFFFFF06F, 32'h0, 32'h0, 32'hFFFFF017, 32'h0};
    do_flush();
    for (int i = 0; i < 12; i++) begin
      req(ops[i], 5'd0, 5'd0, 5'd0, imms[i]);
      tick();
      checks++;
      if (out_valid !== lg[i]) begin
        errors++;
        $display("FAIL bound%0d_valid op=%0d imm=%h got v=%0b want %0b",
                 i, ops[i], imms[i], out_valid, lg[i]);
      end
      if (lg[i]) begin
        checks++;
        if (out_data !== words[i]) begin
          errors++;
          $display("FAIL bound%0d_word got %h want %h", i, out_data, words[i]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({err, err_op, err_count, instr_count} !== {1'b1, 6'd37, 16'd6, 16'd6}) begin
      errors++;
      $display("FAIL bound_status got e=%0b eo=%0d ec=%0d ic=%0d want e=1 eo=37 ec=6 ic=6",
               err, err_op, err_count, instr_count);
    end
  endtask

  task automatic test_backpressure;
    do_flush();
    out_ready = 1'b0;
    req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, out_addr, out_data} !== {1'b0, 1'b1, 32'h0, 32'h002081B3}) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%0b v=%0b a=%h d=%h want rdy=0 v=1 a=00000000 d=002081b3",
                 i, in_ready, out_valid, out_addr, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %0b want 1", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_addr, out_data} !== {1'b1, 32'h4, 32'hFFF00093}) begin
      errors++;
      $display("FAIL bp_second got v=%0b a=%h d=%h want v=1 a=00000004 d=fff00093",
               out_valid, out_addr, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, instr_count} !== {1'b0, 16'd2}) begin
      errors++;
      $display("FAIL bp_count got v=%0b ic=%0d want v=0 ic=2", out_valid, instr_count);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a [6];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    do_flush();
    for (int i = 0; i < 6; i++) begin
      req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
      tick();
      checks++;
      if ({out_valid, out_addr} !== {1'b1, exp_a[i]}) begin
        errors++;
        $display("FAIL wrap%0d got v=%0b a=%h want v=1 a=%h", i, out_valid, out_addr, exp_a[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (instr_count !== 16'd6) begin
      errors++;
      $display("FAIL wrap_count got %0d want 6", instr_count);
    end
  endtask

  task automatic test_async_reset;
    do_flush();
    req(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_addr, out_data, err, err_op, err_count, instr_count} !==
        {1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL async_reset got v=%0b a=%h d=%h e=%0b eo=%0d ec=%0d ic=%0d want all zero",
               out_valid, out_addr, out_data, err, err_op, err_count, instr_count);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_flush;
    req(6'd40, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %0b want 1", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_addr, err, err_count, instr_count} !== {1'b0, 32'h0, 1'b0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL flush_state got v=%0b a=%h e=%0b ec=%0d ic=%0d want v=0 a=00000000 e=0 ec=0 ic=0",
               out_valid, out_addr, err, err_count, instr_count);
    end
  endtask

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_back_to_back();
    test_formats();
    test_illegal();
    test_boundaries();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
